// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Request, completion and memory-bus signals of the fetch/LSQ
//               memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if;
    logic        flush;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_data;
    logic [3:0]  lsq_op;
    logic [31:0] lsq_addr;
    logic [31:0] lsq_wdata;
    logic        lsq_rd_ready;
    logic        lsq_wr_ready;
    logic [31:0] lsq_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    // Requesters plus memory model: drives requests and read data.
    modport master (
        output flush, if_req, if_addr, lsq_op, lsq_addr, lsq_wdata, mem_rdata,
        input  if_ready, if_data, lsq_rd_ready, lsq_wr_ready, lsq_rdata,
               mem_en, mem_we, mem_wmask, mem_addr, mem_wdata
    );

    // Arbiter side.
    modport slave (
        input  flush, if_req, if_addr, lsq_op, lsq_addr, lsq_wdata, mem_rdata,
        output if_ready, if_data, lsq_rd_ready, lsq_wr_ready, lsq_rdata,
               mem_en, mem_we, mem_wmask, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one memory port between instruction fetch and the LSQ,
//               with LSQ priority, fetch anti-starvation and flush squashing.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int MEM_LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);
    typedef enum logic [0:0] {S_IDLE = 1'b0, S_ACCESS = 1'b1} state_t;

    localparam logic [1:0] K_FETCH  = 2'd0;
    localparam logic [1:0] K_LOAD   = 2'd1;
    localparam logic [1:0] K_STORE  = 2'd2;
    localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic [1:0]  streak;
    logic        pend_valid;
    logic [3:0]  pend_op;
    logic [31:0] pend_addr;
    logic [31:0] pend_wdata;
    logic [1:0]  cur_kind;
    logic [2:0]  cur_op;
    logic [1:0]  cur_off;
    logic        squash;

    logic        live_valid;
    logic        pend_keep;
    logic        fetch_ok;
    logic        grant_fetch;
    logic        grant_lsq;
    logic        latch_live;
    logic [3:0]  sel_op;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << {off[1], 1'b0};
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [1:0] off,
                                              input logic [31:0] wdata);
        case (size)
            2'b00:   return 32'(wdata[7:0]) << {off, 3'b000};
            2'b01:   return 32'(wdata[15:0]) << {off[1], 4'b0000};
            default: return wdata;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] op, input logic [1:0] off,
                                             input logic [31:0] rdata);
        logic [31:0] sh;
        sh = rdata >> {off, 3'b000};
        case (op[1:0])
            2'b00:   return op[2] ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'b01:   return op[2] ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    // A flush kills loads (live or pending) but never stores.
    always_comb begin
        live_valid  = (bus.lsq_op != 4'd0) && !(bus.flush && !bus.lsq_op[3]);
        pend_keep   = pend_valid && !(bus.flush && !pend_op[3]);
        fetch_ok    = bus.if_req && !bus.flush && !bus.if_ready;
        grant_fetch = (state == S_IDLE) && fetch_ok &&
                      (!(pend_keep || live_valid) || (streak == 2'd2));
        grant_lsq   = (state == S_IDLE) && (pend_keep || live_valid) && !grant_fetch;
        latch_live  = live_valid && !pend_keep && !grant_lsq;
        sel_op      = pend_keep ? pend_op    : bus.lsq_op;
        sel_addr    = pend_keep ? pend_addr  : bus.lsq_addr;
        sel_wdata   = pend_keep ? pend_wdata : bus.lsq_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            cnt              <= 4'd0;
            streak           <= 2'd0;
            pend_valid       <= 1'b0;
            pend_op          <= 4'd0;
            pend_addr        <= 32'd0;
            pend_wdata       <= 32'd0;
            cur_kind         <= K_FETCH;
            cur_op           <= 3'd0;
            cur_off          <= 2'd0;
            squash           <= 1'b0;
            bus.if_ready     <= 1'b0;
            bus.if_data      <= 32'd0;
            bus.lsq_rd_ready <= 1'b0;
            bus.lsq_wr_ready <= 1'b0;
            bus.lsq_rdata    <= 32'd0;
            bus.mem_en       <= 1'b0;
            bus.mem_we       <= 1'b0;
            bus.mem_wmask    <= 4'd0;
            bus.mem_addr     <= 32'd0;
            bus.mem_wdata    <= 32'd0;
        end else begin
            bus.if_ready     <= 1'b0;
            bus.if_data      <= 32'd0;
            bus.lsq_rd_ready <= 1'b0;
            bus.lsq_wr_ready <= 1'b0;
            bus.lsq_rdata    <= 32'd0;

            pend_valid <= latch_live | (pend_keep & ~grant_lsq);
            if (latch_live) begin
                pend_op    <= bus.lsq_op;
                pend_addr  <= bus.lsq_addr;
                pend_wdata <= bus.lsq_wdata;
            end

            case (state)
                S_IDLE: begin
                    if (grant_fetch || grant_lsq) begin
                        state      <= S_ACCESS;
                        cnt        <= CNT_INIT;
                        squash     <= 1'b0;
                        bus.mem_en <= 1'b1;
                    end
                    if (grant_fetch) begin
                        cur_kind      <= K_FETCH;
                        streak        <= 2'd0;
                        bus.mem_addr  <= bus.if_addr & ~32'd3;
                        bus.mem_we    <= 1'b0;
                        bus.mem_wmask <= 4'd0;
                        bus.mem_wdata <= 32'd0;
                    end else if (grant_lsq) begin
                        cur_kind      <= sel_op[3] ? K_STORE : K_LOAD;
                        cur_op        <= sel_op[2:0];
                        cur_off       <= sel_addr[1:0];
                        // Streak only grows while fetch was actually waiting.
                        streak        <= !fetch_ok ? 2'd0 :
                                         (streak == 2'd2) ? 2'd2 : streak + 2'd1;
                        bus.mem_addr  <= {sel_addr[31:2], 2'b00};
                        bus.mem_we    <= sel_op[3];
                        bus.mem_wmask <= sel_op[3] ? lane_mask(sel_op[1:0], sel_addr[1:0]) : 4'd0;
                        bus.mem_wdata <= sel_op[3] ? lane_data(sel_op[1:0], sel_addr[1:0], sel_wdata)
                                                   : 32'd0;
                    end
                end
                S_ACCESS: begin
                    if (bus.flush && cur_kind != K_STORE) begin
                        squash <= 1'b1;
                    end
                    if (cnt == 4'd0) begin
                        state         <= S_IDLE;
                        bus.mem_en    <= 1'b0;
                        bus.mem_we    <= 1'b0;
                        bus.mem_wmask <= 4'd0;
                        bus.mem_addr  <= 32'd0;
                        bus.mem_wdata <= 32'd0;
                        if (cur_kind == K_STORE) begin
                            bus.lsq_wr_ready <= 1'b1;
                        end else if (!(squash || bus.flush)) begin
                            if (cur_kind == K_FETCH) begin
                                bus.if_ready <= 1'b1;
                                bus.if_data  <= bus.mem_rdata;
                            end else begin
                                bus.lsq_rd_ready <= 1'b1;
                                bus.lsq_rdata    <= load_ext(cur_op, cur_off, bus.mem_rdata);
                            end
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter, MEM_LATENCY=2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.MEM_LATENCY(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One cycle: outputs are sampled and inputs driven on the falling edge.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic quiet();
        bus.flush  = 1'b0;
        bus.if_req = 1'b0;
        bus.lsq_op = 4'd0;
    endtask

    task automatic run_store(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [3:0] emask, input logic [31:0] edata);
        cyc(); bus.lsq_op = op; bus.lsq_addr = addr; bus.lsq_wdata = wd;
        cyc(); bus.lsq_op = 4'd0;
        check("st_we",    32'(bus.mem_we), 32'd1);
        check("st_mask",  32'(bus.mem_wmask), 32'(emask));
        check("st_wdata", bus.mem_wdata, edata);
        check("st_addr",  bus.mem_addr, {addr[31:2], 2'b00});
        cyc(); check("st_mask_hold", 32'(bus.mem_wmask), 32'(emask));
        cyc(); check("st_wr_ready", 32'(bus.lsq_wr_ready), 32'd1);
        cyc(); check("st_done_en", 32'(bus.mem_en), 32'd0);
    endtask

    task automatic run_load(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] rd,
                            input logic [31:0] exp);
        cyc(); bus.lsq_op = op; bus.lsq_addr = addr; bus.mem_rdata = rd;
        cyc(); bus.lsq_op = 4'd0;
        check("ld_we",   32'(bus.mem_we), 32'd0);
        check("ld_addr", bus.mem_addr, {addr[31:2], 2'b00});
        cyc();
        cyc(); check("ld_rd_ready", 32'(bus.lsq_rd_ready), 32'd1);
        check("ld_rdata", bus.lsq_rdata, exp);
        cyc();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        quiet();
        bus.if_addr   = 32'd0;
        bus.lsq_addr  = 32'd0;
        bus.lsq_wdata = 32'd0;
        bus.mem_rdata = 32'd0;
        repeat (3) cyc();
        check("rst_en",    32'(bus.mem_en), 32'd0);
        check("rst_addr",  bus.mem_addr, 32'd0);
        check("rst_ifrdy", 32'(bus.if_ready), 32'd0);
        check("rst_rdrdy", 32'(bus.lsq_rd_ready), 32'd0);
        rst = 1'b0;
        cyc();

        // Plain fetch; if_req still high in its ready cycle must not regrant.
        cyc(); bus.if_req = 1'b1; bus.if_addr = 32'h40; bus.mem_rdata = 32'h12345678;
        check("f_c0_en", 32'(bus.mem_en), 32'd0);
        cyc(); check("f_c1_en", 32'(bus.mem_en), 32'd1);
        check("f_c1_addr", bus.mem_addr, 32'h40);
        check("f_c1_we", 32'(bus.mem_we), 32'd0);
        cyc(); check("f_c2_en", 32'(bus.mem_en), 32'd1);
        check("f_c2_rdy", 32'(bus.if_ready), 32'd0);
        cyc(); check("f_c3_rdy", 32'(bus.if_ready), 32'd1);
        check("f_c3_data", bus.if_data, 32'h12345678);
        check("f_c3_en", 32'(bus.mem_en), 32'd0);
        cyc(); bus.if_req = 1'b0;
        check("f_c4_no_regrant", 32'(bus.mem_en), 32'd0);
        check("f_c4_rdy", 32'(bus.if_ready), 32'd0);
        repeat (2) cyc();

        // Collision: LSQ first, fetch granted in its ready cycle.
        cyc(); bus.lsq_op = 4'b0010; bus.lsq_addr = 32'h100;
        bus.if_req = 1'b1; bus.if_addr = 32'h80; bus.mem_rdata = 32'hCAFEF00D;
        cyc(); bus.lsq_op = 4'd0;
        check("col_c1_addr", bus.mem_addr, 32'h100);
        cyc();
        cyc(); check("col_c3_rdrdy", 32'(bus.lsq_rd_ready), 32'd1);
        check("col_c3_rdata", bus.lsq_rdata, 32'hCAFEF00D);
        cyc(); check("col_c4_addr", bus.mem_addr, 32'h80);
        check("col_c4_en", 32'(bus.mem_en), 32'd1);
        cyc();
        cyc(); check("col_c6_ifrdy", 32'(bus.if_ready), 32'd1);
        check("col_c6_data", bus.if_data, 32'hCAFEF00D);
        cyc(); bus.if_req = 1'b0;
        repeat (2) cyc();

        run_store(4'b1000, 32'h103, 32'h000000AB, 4'b1000, 32'hAB000000);
        run_store(4'b1000, 32'h101, 32'hFFFFFF5A, 4'b0010, 32'h00005A00);
        run_store(4'b1001, 32'h102, 32'h00001234, 4'b1100, 32'h12340000);
        run_store(4'b1001, 32'h103, 32'h00005678, 4'b1100, 32'h56780000);
        run_store(4'b1010, 32'h204, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF);

        run_load(4'b0001, 32'h102, 32'h80010000, 32'hFFFF8001);
        run_load(4'b0101, 32'h102, 32'h80010000, 32'h00008001);
        run_load(4'b0001, 32'h100, 32'h00007FFF, 32'h00007FFF);
        run_load(4'b0100, 32'h101, 32'h0000F300, 32'h000000F3);
        run_load(4'b0100, 32'h103, 32'h9A000000, 32'h0000009A);
        run_load(4'b0010, 32'h108, 32'h89ABCDEF, 32'h89ABCDEF);

        // Starvation: two LSQ grants with fetch waiting, then fetch wins.
        cyc(); bus.lsq_op = 4'b0010; bus.lsq_addr = 32'h10;
        bus.if_req = 1'b1; bus.if_addr = 32'h300;
        cyc(); bus.lsq_addr = 32'h14;
        check("stv_g1_addr", bus.mem_addr, 32'h10);
        cyc(); bus.lsq_op = 4'd0;
        cyc(); check("stv_c3_rdrdy", 32'(bus.lsq_rd_ready), 32'd1);
        cyc(); bus.lsq_op = 4'b0010; bus.lsq_addr = 32'h18;
        check("stv_g2_addr", bus.mem_addr, 32'h14);
        cyc(); bus.lsq_op = 4'd0;
        cyc();
        cyc(); check("stv_g3_fetch_addr", bus.mem_addr, 32'h300);
        check("stv_g3_we", 32'(bus.mem_we), 32'd0);
        cyc();
        cyc(); check("stv_c9_ifrdy", 32'(bus.if_ready), 32'd1);
        cyc(); bus.if_req = 1'b0;
        check("stv_g4_addr", bus.mem_addr, 32'h18);
        cyc();
        cyc(); check("stv_c12_rdrdy", 32'(bus.lsq_rd_ready), 32'd1);
        repeat (2) cyc();

        // Flush hits in-flight load while a store is accepted in the same cycle.
        cyc(); bus.lsq_op = 4'b0010; bus.lsq_addr = 32'h20;
        cyc(); bus.lsq_op = 4'b1000; bus.lsq_addr = 32'h24; bus.lsq_wdata = 32'h11; bus.flush = 1'b1;
        cyc(); quiet();
        cyc(); check("fl_c3_no_rdrdy", 32'(bus.lsq_rd_ready), 32'd0);
        cyc(); check("fl_st_we", 32'(bus.mem_we), 32'd1);
        check("fl_st_addr", bus.mem_addr, 32'h24);
        check("fl_st_mask", 32'(bus.mem_wmask), 32'h1);
        check("fl_st_wdata", bus.mem_wdata, 32'h11);
        cyc(); check("fl_c5_wrrdy", 32'(bus.lsq_wr_ready), 32'd0);
        cyc(); check("fl_c6_wrrdy", 32'(bus.lsq_wr_ready), 32'd1);
        check("fl_c6_rdrdy", 32'(bus.lsq_rd_ready), 32'd0);
        repeat (2) cyc();

        // Load arriving with flush is discarded.
        cyc(); bus.lsq_op = 4'b0010; bus.lsq_addr = 32'h28; bus.flush = 1'b1;
        cyc(); quiet();
        check("flld_en", 32'(bus.mem_en), 32'd0);
        repeat (3) cyc();
        check("flld_rdrdy", 32'(bus.lsq_rd_ready), 32'd0);

        // Flush drops a pending load behind an in-flight store.
        cyc(); bus.lsq_op = 4'b1010; bus.lsq_addr = 32'h40; bus.lsq_wdata = 32'h5;
        cyc(); bus.lsq_op = 4'b0010; bus.lsq_addr = 32'h44;
        cyc(); bus.lsq_op = 4'd0; bus.flush = 1'b1;
        cyc(); bus.flush = 1'b0;
        check("flpd_wrrdy", 32'(bus.lsq_wr_ready), 32'd1);
        cyc(); check("flpd_no_grant", 32'(bus.mem_en), 32'd0);
        repeat (2) cyc();

        // A third command while pending is occupied is ignored.
        cyc(); bus.lsq_op = 4'b0010; bus.lsq_addr = 32'h50;
        cyc(); bus.lsq_addr = 32'h54;
        cyc(); bus.lsq_addr = 32'h58;
        cyc(); bus.lsq_op = 4'd0;
        cyc(); check("pe_addr", bus.mem_addr, 32'h54);
        cyc();
        cyc(); check("pe_rdrdy", 32'(bus.lsq_rd_ready), 32'd1);
        cyc(); check("pe_no_third", 32'(bus.mem_en), 32'd0);
        repeat (2) cyc();

        // Reset mid-access: no completion pulse afterwards.
        cyc(); bus.lsq_op = 4'b0010; bus.lsq_addr = 32'h60;
        cyc(); bus.lsq_op = 4'd0; rst = 1'b1;
        check("rm_en_before", 32'(bus.mem_en), 32'd1);
        cyc(); rst = 1'b0;
        check("rm_en_after", 32'(bus.mem_en), 32'd0);
        check("rm_addr_after", bus.mem_addr, 32'd0);
        cyc(); check("rm_no_rdrdy", 32'(bus.lsq_rd_ready), 32'd0);
        cyc(); check("rm_no_rdrdy2", 32'(bus.lsq_rd_ready), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
